// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings and helpers for the memory access unit
package mem_access_pkg;

    localparam logic [1:0] MMU_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] MMU_WIDTH_HALF = 2'd1;
    localparam logic [1:0] MMU_WIDTH_WORD = 2'd2;
    localparam logic [1:0] MMU_WIDTH_RSVD = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ACC1 = 3'd1;
    localparam logic [2:0] ST_ACC2 = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    function automatic logic [2:0] width_bytes(input logic [1:0] width);
        case (width)
            MMU_WIDTH_BYTE: width_bytes = 3'd1;
            MMU_WIDTH_HALF: width_bytes = 3'd2;
            MMU_WIDTH_WORD: width_bytes = 3'd4;
            default:        width_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for stores and load reassembly/extension
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  wr_off,
    input  logic [1:0]  wr_width,
    input  logic [31:0] wr_data,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    input  logic [1:0]  rd_off,
    input  logic [1:0]  rd_width,
    input  logic        rd_signed,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [31:0] rdata
);

    logic [3:0]  lane_mask;
    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic [63:0] rdata_wide;
    logic [31:0] raw;

    // Treat the two words as one 64-bit window so split accesses fall out of a shift.
    always_comb begin
        case (wr_width)
            MMU_WIDTH_BYTE: lane_mask = 4'b0001;
            MMU_WIDTH_HALF: lane_mask = 4'b0011;
            default:        lane_mask = 4'b1111;
        endcase
        be_wide    = {4'b0000, lane_mask} << wr_off;
        wdata_wide = {32'd0, wr_data} << {wr_off, 3'b000};
        rdata_wide = {word1, word0} >> {rd_off, 3'b000};
        raw        = rdata_wide[31:0];
        case (rd_width)
            MMU_WIDTH_BYTE: rdata = {{24{rd_signed & raw[7]}}, raw[7:0]};
            MMU_WIDTH_HALF: rdata = {{16{rd_signed & raw[15]}}, raw[15:0]};
            default:        rdata = raw;
        endcase
    end

    assign be0    = be_wide[3:0];
    assign be1    = be_wide[7:4];
    assign wdata0 = wdata_wide[31:0];
    assign wdata1 = wdata_wide[63:32];

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store unit onto one word-wide memory port
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int          MEM_ADDR_W  = 8,
    parameter logic [31:0] MAP_BASE    = 32'h0100_0000,
    parameter bit          MISALIGN_EN = 1'b1,
    parameter bit          READ_ONLY   = 1'b0
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_signed,
    input  logic [1:0]            req_width,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [33:0] WINDOW_BYTES = 34'd4 << MEM_ADDR_W;

    logic [2:0]  state;
    logic        cap_write, cap_signed, cap_split;
    logic [1:0]  cap_width, cap_off;
    logic [3:0]  cap_be1;
    logic [31:0] cap_wdata1, word0;

    logic [31:0] rel_addr;
    logic [2:0]  nbytes;
    logic        split, unaligned, in_window, fault;
    logic [3:0]  be0, be1;
    logic [31:0] wdata0, wdata1, merged, rd_word0;

    // With splitting disabled any non-naturally-aligned access is rejected, which also covers every word-crossing one.
    always_comb begin
        rel_addr  = req_addr - MAP_BASE;
        nbytes    = width_bytes(req_width);
        split     = ({1'b0, req_addr[1:0]} + nbytes) > 3'd4;
        unaligned = ((req_width == MMU_WIDTH_HALF) && req_addr[0]) ||
                    ((req_width == MMU_WIDTH_WORD) && (req_addr[1:0] != 2'b00));
        in_window = (req_addr >= MAP_BASE) &&
                    (({2'b00, rel_addr} + {31'd0, nbytes}) <= WINDOW_BYTES);
        fault     = (req_width == MMU_WIDTH_RSVD) || !in_window ||
                    (!MISALIGN_EN && unaligned) || (req_write && READ_ONLY);
    end

    assign rd_word0 = cap_split ? word0 : mem_rdata;

    mem_lane_align u_align (
        .wr_off    (req_addr[1:0]),
        .wr_width  (req_width),
        .wr_data   (req_wdata),
        .be0       (be0),
        .be1       (be1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .rd_off    (cap_off),
        .rd_width  (cap_width),
        .rd_signed (cap_signed),
        .word0     (rd_word0),
        .word1     (mem_rdata),
        .rdata     (merged)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'd0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            cap_write  <= 1'b0;
            cap_signed <= 1'b0;
            cap_split  <= 1'b0;
            cap_width  <= 2'd0;
            cap_off    <= 2'd0;
            cap_be1    <= 4'd0;
            cap_wdata1 <= 32'd0;
            word0      <= 32'd0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= 4'd0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (fault) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                        end else begin
                            state      <= ST_ACC1;
                            mem_en     <= 1'b1;
                            mem_we     <= req_write;
                            mem_be     <= req_write ? be0 : 4'd0;
                            mem_addr   <= rel_addr[MEM_ADDR_W+1:2];
                            mem_wdata  <= req_write ? wdata0 : 32'd0;
                            cap_write  <= req_write;
                            cap_signed <= req_signed;
                            cap_width  <= req_width;
                            cap_off    <= req_addr[1:0];
                            cap_split  <= split;
                            cap_be1    <= be1;
                            cap_wdata1 <= wdata1;
                        end
                    end
                end
                ST_ACC1: begin
                    if (cap_split) begin
                        state     <= ST_ACC2;
                        mem_en    <= 1'b1;
                        mem_we    <= cap_write;
                        mem_be    <= cap_write ? cap_be1 : 4'd0;
                        mem_addr  <= mem_addr + MEM_ADDR_W'(1);
                        mem_wdata <= cap_write ? cap_wdata1 : 32'd0;
                    end else if (cap_write) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_ACC2: begin
                    if (cap_write) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        word0 <= mem_rdata;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    resp_rdata <= merged;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= 32'd0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int          AW     = 4;
    localparam int          WORDS  = 1 << AW;
    localparam int          WBYTES = 4 * WORDS;
    localparam logic [31:0] BASE   = 32'h0100_0000;

    logic clk = 1'b0;
    logic reset_n;
    logic req_valid, req_write, req_signed;
    logic [1:0] req_width;
    logic [31:0] req_addr, req_wdata;
    logic req_ready, resp_valid, resp_fault, mem_en, mem_we;
    logic [31:0] resp_rdata, mem_wdata, mem_rdata;
    logic [3:0] mem_be;
    logic [AW-1:0] mem_addr;

    logic na_valid, na_ready, na_resp_valid, na_resp_fault, na_mem_en, na_mem_we;
    logic [31:0] na_resp_rdata, na_mem_wdata;
    logic [3:0] na_mem_be;
    logic [AW-1:0] na_mem_addr;
    logic ro_valid, ro_ready, ro_resp_valid, ro_resp_fault, ro_mem_en, ro_mem_we;
    logic [31:0] ro_resp_rdata, ro_mem_wdata;
    logic [3:0] ro_mem_be;
    logic [AW-1:0] ro_mem_addr;
    logic [31:0] zero_rdata = 32'd0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ram [WORDS];
    logic [7:0]  ref_mem [WBYTES];
    logic [AW-1:0] log_addr [$];
    logic [3:0]    log_be [$];
    logic [31:0]   log_wdata [$];

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_ADDR_W(AW), .MAP_BASE(BASE), .MISALIGN_EN(1'b1), .READ_ONLY(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_signed(req_signed), .req_width(req_width),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_en(mem_en), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.MEM_ADDR_W(AW), .MAP_BASE(BASE), .MISALIGN_EN(1'b0), .READ_ONLY(1'b0)) dut_na (
        .clk(clk), .reset_n(reset_n), .req_valid(na_valid), .req_ready(na_ready),
        .req_write(req_write), .req_signed(req_signed), .req_width(req_width),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(na_resp_valid),
        .resp_rdata(na_resp_rdata), .resp_fault(na_resp_fault), .mem_en(na_mem_en), .mem_we(na_mem_we),
        .mem_be(na_mem_be), .mem_addr(na_mem_addr), .mem_wdata(na_mem_wdata), .mem_rdata(zero_rdata)
    );

    mem_access_unit #(.MEM_ADDR_W(AW), .MAP_BASE(BASE), .MISALIGN_EN(1'b1), .READ_ONLY(1'b1)) dut_ro (
        .clk(clk), .reset_n(reset_n), .req_valid(ro_valid), .req_ready(ro_ready),
        .req_write(req_write), .req_signed(req_signed), .req_width(req_width),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(ro_resp_valid),
        .resp_rdata(ro_resp_rdata), .resp_fault(ro_resp_fault), .mem_en(ro_mem_en), .mem_we(ro_mem_we),
        .mem_be(ro_mem_be), .mem_addr(ro_mem_addr), .mem_wdata(ro_mem_wdata), .mem_rdata(zero_rdata)
    );

    function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Synchronous RAM behind the main instance, logging every strobe.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            log_addr.push_back(mem_addr);
            log_be.push_back(mem_be);
            log_wdata.push_back(mem_wdata);
            if (mem_we) ram[mem_addr] <= be_merge(ram[mem_addr], mem_wdata, mem_be);
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic set_word(input int i, input logic [31:0] v);
        ram[i] = v;
        for (int b = 0; b < 4; b++) ref_mem[4*i+b] = v[8*b +: 8];
    endtask

    // Byte-array reference: fault rules, latency by access kind, byte-wise load/store.
    task automatic model(input logic w, input logic s, input logic [1:0] wd, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rd,
                         output logic flt, output int nacc, output int waddr);
        int n, rel;
        longint la;
        logic split;
        logic [31:0] v;
        n = (wd == 2'd0) ? 1 : (wd == 2'd1) ? 2 : (wd == 2'd2) ? 4 : 0;
        la = longint'(a);
        flt = (wd == 2'd3) || (la < longint'(BASE)) || (la + n > longint'(BASE) + WBYTES);
        split = (int'(a % 4) + n) > 4;
        rd = 32'd0; nacc = 0; waddr = 0;
        if (flt) begin
            lat = 1;
        end else begin
            rel = int'(la - longint'(BASE));
            waddr = rel / 4;
            nacc = split ? 2 : 1;
            if (w) begin
                lat = split ? 3 : 2;
                for (int i = 0; i < n; i++) ref_mem[rel+i] = d[8*i +: 8];
            end else begin
                lat = split ? 4 : 3;
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[rel+i];
                if (s && n < 4 && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                rd = v;
            end
        end
    endtask

    task automatic issue(input logic w, input logic s, input logic [1:0] wd, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rd,
                         output logic flt, output int nacc, output int st);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_signed = s; req_width = wd; req_addr = a; req_wdata = d;
        st = log_addr.size();
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_signed = 1'($urandom);
        req_width = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = -1; rd = 32'hDEAD_BEEF; flt = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                lat = c; rd = resp_rdata; flt = resp_fault;
                break;
            end
        end
        nacc = log_addr.size() - st;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, resp_rdata, resp_fault, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !==
            {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, {AW{1'b0}}, 32'd0}) begin
            n_err++;
            $display("FAIL reset_main: ready=%b rv=%b rd=%h flt=%b en=%b we=%b be=%h addr=%h wd=%h",
                     req_ready, resp_valid, resp_rdata, resp_fault, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
        end
        n_cmp++;
        if ({na_ready, na_resp_valid, na_resp_rdata, na_resp_fault, na_mem_en, na_mem_we, na_mem_be, na_mem_addr, na_mem_wdata,
             ro_ready, ro_resp_valid, ro_resp_rdata, ro_resp_fault, ro_mem_en, ro_mem_we, ro_mem_be, ro_mem_addr, ro_mem_wdata} !==
            {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, {AW{1'b0}}, 32'd0,
             1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, {AW{1'b0}}, 32'd0}) begin
            n_err++;
            $display("FAIL reset_variants: na_ready=%b ro_ready=%b na_en=%b ro_en=%b", na_ready, ro_ready, na_mem_en, ro_mem_en);
        end
    endtask

    task automatic test_directed;
        int lat, nacc, st, e_lat, e_nacc, e_wa;
        logic [31:0] rd, e_rd, w0, w1;
        logic flt, e_flt;
        set_word(0, 32'h4433_2211);
        set_word(1, 32'h8877_6655);
        issue(1'b0, 1'b1, 2'd0, BASE + 32'd7, 32'd0, lat, rd, flt, nacc, st);
        n_cmp++;
        if (lat !== 3 || rd !== 32'hFFFF_FF88 || flt !== 1'b0) begin
            n_err++; $display("FAIL sbyte_load: lat=%0d rd=%h flt=%b want lat=3 rd=ffffff88 flt=0", lat, rd, flt);
        end
        n_cmp++;
        if (nacc !== 1 || log_addr[st] !== AW'(1)) begin
            n_err++; $display("FAIL sbyte_load_addr: nacc=%0d addr=%0d want 1 access at 1", nacc, log_addr[st]);
        end
        issue(1'b0, 1'b1, 2'd1, BASE + 32'd3, 32'd0, lat, rd, flt, nacc, st);
        n_cmp++;
        if (lat !== 4 || rd !== 32'h0000_5544 || flt !== 1'b0) begin
            n_err++; $display("FAIL mis_half_load: lat=%0d rd=%h flt=%b want lat=4 rd=00005544 flt=0", lat, rd, flt);
        end
        n_cmp++;
        if (nacc !== 2 || log_addr[st] !== AW'(0) || log_addr[st+1] !== AW'(1)) begin
            n_err++; $display("FAIL mis_half_addr: nacc=%0d want reads at 0 then 1", nacc);
        end
        model(1'b1, 1'b0, 2'd2, BASE + 32'd2, 32'hAABB_CCDD, e_lat, e_rd, e_flt, e_nacc, e_wa);
        issue(1'b1, 1'b0, 2'd2, BASE + 32'd2, 32'hAABB_CCDD, lat, rd, flt, nacc, st);
        n_cmp++;
        if (lat !== 3 || flt !== 1'b0 || nacc !== 2) begin
            n_err++; $display("FAIL mis_word_store: lat=%0d flt=%b nacc=%0d want lat=3 flt=0 nacc=2", lat, flt, nacc);
        end else begin
            w0 = log_wdata[st]; w1 = log_wdata[st+1];
            n_cmp++;
            if (log_addr[st] !== AW'(0) || log_be[st] !== 4'b1100 || w0[31:16] !== 16'hCCDD ||
                log_addr[st+1] !== AW'(1) || log_be[st+1] !== 4'b0011 || w1[15:0] !== 16'hAABB) begin
                n_err++; $display("FAIL mis_word_lanes: be=%b/%b wdata=%h/%h want 1100/0011 ccddxxxx/xxxxaabb",
                                  log_be[st], log_be[st+1], w0, w1);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (ram[0] !== 32'hCCDD_2211 || ram[1] !== 32'h8877_AABB) begin
            n_err++; $display("FAIL mis_word_mem: w0=%h w1=%h want ccdd2211 8877aabb", ram[0], ram[1]);
        end
    endtask

    task automatic test_faults;
        int lat, nacc, st;
        logic [31:0] rd;
        logic flt;
        issue(1'b0, 1'b0, 2'd2, BASE + WBYTES - 2, 32'd0, lat, rd, flt, nacc, st);
        n_cmp++;
        if (lat !== 1 || flt !== 1'b1 || nacc !== 0 || rd !== 32'd0) begin
            n_err++; $display("FAIL fault_top_edge: lat=%0d flt=%b nacc=%0d rd=%h want 1/1/0/0", lat, flt, nacc, rd);
        end
        issue(1'b0, 1'b0, 2'd2, 32'h0000_0010, 32'd0, lat, rd, flt, nacc, st);
        n_cmp++;
        if (lat !== 1 || flt !== 1'b1 || nacc !== 0) begin
            n_err++; $display("FAIL fault_below: lat=%0d flt=%b nacc=%0d want 1/1/0", lat, flt, nacc);
        end
        issue(1'b0, 1'b0, 2'd3, BASE, 32'd0, lat, rd, flt, nacc, st);
        n_cmp++;
        if (lat !== 1 || flt !== 1'b1 || nacc !== 0) begin
            n_err++; $display("FAIL fault_width3: lat=%0d flt=%b nacc=%0d want 1/1/0", lat, flt, nacc);
        end
        @(negedge clk);
        na_valid = 1'b1; req_write = 1'b0; req_signed = 1'b0; req_width = 2'd1; req_addr = BASE + 32'd1;
        @(posedge clk);
        #1 na_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({na_resp_valid, na_resp_fault, na_mem_en} !== 3'b110) begin
            n_err++; $display("FAIL fault_noalign: valid/fault/en=%b%b%b want 110", na_resp_valid, na_resp_fault, na_mem_en);
        end
        @(negedge clk);
        ro_valid = 1'b1; req_write = 1'b1; req_width = 2'd0; req_addr = BASE; req_wdata = 32'h55;
        @(posedge clk);
        #1 ro_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ro_resp_valid, ro_resp_fault, ro_mem_en} !== 3'b110) begin
            n_err++; $display("FAIL fault_readonly: valid/fault/en=%b%b%b want 110", ro_resp_valid, ro_resp_fault, ro_mem_en);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int a_lat, a_nacc, a_wa, b_lat, b_nacc, b_wa, got;
        logic [31:0] a_rd, b_rd, got_rd;
        logic a_flt, b_flt;
        model(1'b0, 1'b1, 2'd1, BASE + 32'd7, 32'd0, a_lat, a_rd, a_flt, a_nacc, a_wa);
        model(1'b0, 1'b0, 2'd2, BASE + 32'd8, 32'd0, b_lat, b_rd, b_flt, b_nacc, b_wa);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_signed = 1'b1; req_width = 2'd1; req_addr = BASE + 32'd7;
        @(posedge clk);
        #1;
        req_signed = 1'b0; req_width = 2'd2; req_addr = BASE + 32'd8;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== (c == 5)) begin
                n_err++; $display("FAIL b2b_ready_c%0d: ready=%b want %b", c, req_ready, (c == 5));
            end
            if (c == 4) begin
                n_cmp++;
                if (resp_valid !== 1'b1 || resp_rdata !== a_rd) begin
                    n_err++; $display("FAIL b2b_first_resp: valid=%b rd=%h want 1 %h", resp_valid, resp_rdata, a_rd);
                end
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_en !== 1'b1 || mem_addr !== AW'(b_wa)) begin
            n_err++; $display("FAIL b2b_second_accept: en=%b addr=%0d want 1 %0d", mem_en, mem_addr, b_wa);
        end
        got = -1; got_rd = 32'hDEAD_BEEF;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin got = c; got_rd = resp_rdata; break; end
        end
        n_cmp++;
        if (got !== b_lat || got_rd !== b_rd) begin
            n_err++; $display("FAIL b2b_second_resp: lat=%0d rd=%h want %0d %h", got, got_rd, b_lat, b_rd);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_signed = 1'b0; req_width = 2'd2; req_addr = BASE + 32'h21;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (mem_en !== 1'b1 || mem_addr !== AW'(9)) begin
            n_err++; $display("FAIL rst_mid_acc2: en=%b addr=%0d want 1 9", mem_en, mem_addr);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || resp_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_async: en=%b we=%b rv=%b want 000", mem_en, mem_we, resp_valid);
        end
        seen = 1'b0;
        repeat (2) begin @(negedge clk); seen |= resp_valid; end
        reset_n = 1'b1;
        repeat (6) begin @(negedge clk); seen |= resp_valid; end
        n_cmp++;
        if (seen !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_after: resp_seen=%b ready=%b want 0 1", seen, req_ready);
        end
    endtask

    task automatic test_random;
        int lat, nacc, st, e_lat, e_nacc, e_wa;
        logic [31:0] rd, e_rd, a, d, w;
        logic flt, e_flt, wr, sg;
        logic [1:0] wd;
        logic [3:0] be_or;
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 9))
                0, 1:    a = BASE - 32'd4 + $urandom_range(0, 7);
                2, 3:    a = BASE + WBYTES - 32'd4 + $urandom_range(0, 7);
                4:       a = $urandom;
                default: a = BASE + $urandom_range(0, WBYTES - 1);
            endcase
            wd = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            wr = 1'($urandom); sg = 1'($urandom); d = $urandom;
            model(wr, sg, wd, a, d, e_lat, e_rd, e_flt, e_nacc, e_wa);
            issue(wr, sg, wd, a, d, lat, rd, flt, nacc, st);
            n_cmp++;
            if (lat !== e_lat || flt !== e_flt) begin
                n_err++; $display("FAIL rnd%0d_lat: a=%h w=%b wd=%0d lat=%0d flt=%b want %0d %b", k, a, wr, wd, lat, flt, e_lat, e_flt);
            end
            n_cmp++;
            if (rd !== e_rd) begin
                n_err++; $display("FAIL rnd%0d_rdata: a=%h wd=%0d s=%b rd=%h want %h", k, a, wd, sg, rd, e_rd);
            end
            n_cmp++;
            if (nacc !== e_nacc) begin
                n_err++; $display("FAIL rnd%0d_nacc: a=%h nacc=%0d want %0d", k, a, nacc, e_nacc);
            end else if (e_nacc > 0) begin
                be_or = 4'd0;
                for (int i = 0; i < nacc; i++) be_or |= log_be[st+i];
                n_cmp++;
                if (log_addr[st] !== AW'(e_wa) || (!wr && be_or !== 4'd0)) begin
                    n_err++; $display("FAIL rnd%0d_addr: addr=%0d be_or=%b want %0d", k, log_addr[st], be_or, e_wa);
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < WORDS; i++) begin
            w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
            n_cmp++;
            if (ram[i] !== w) begin
                n_err++; $display("FAIL final_mem%0d: got=%h want %h", i, ram[i], w);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; na_valid = 1'b0; ro_valid = 1'b0;
        req_write = 1'b0; req_signed = 1'b0; req_width = 2'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < WORDS; i++) set_word(i, $urandom);
        repeat (2) @(negedge clk);
        test_reset;
        reset_n = 1'b1;
        test_directed;
        test_faults;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
